// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared state encoding and defaults for the round-robin bus arbiter
package rr_arb_pkg;
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;
  localparam int DEF_CNT_W = 16;
endpackage

// File: rtl/rr_bus_arbiter_pick.sv
// rr_pick: round-robin one-hot pick, lowest set bit of req starting after ptr
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick
);
  logic [PW-1:0]  sh;
  logic [2*N-1:0] dr;
  logic [2*N-1:0] dl;
  logic [N-1:0]   rot;
  logic [N-1:0]   fp;
  // rotate so ptr+1 lands at bit 0, take lowest set bit, rotate back
  always_comb begin
    sh   = (ptr == PW'(N-1)) ? '0 : ptr + PW'(1);
    dr   = {req, req} >> sh;
    rot  = dr[N-1:0];
    fp   = rot & (~rot + N'(1));
    dl   = {fp, fp} << sh;
    pick = dl[2*N-1:N];
  end
endmodule

// File: rtl/rr_bus_arbiter.sv
// rr_bus_arbiter: round-robin arbiter with burst locking onto one valid/ready bus; RR_ARB_STATS_EN adds grant counters
module rr_bus_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [N-1:0]     req_valid,
  input  logic [N-1:0]     req_last,
  output logic [N-1:0]     req_ready,
  output logic [N-1:0]     sel,
  output logic             bus_valid,
  output logic             bus_last,
  input  logic             bus_ready,
`ifdef RR_ARB_STATS_EN
  output logic             busy,
  output logic [N*CNT_W-1:0] grant_count
`else
  output logic             busy
`endif
);
  localparam int PW = $clog2(N);
  state_t        state;
  state_t        state_nx;
  logic [N-1:0]  grant;
  logic [N-1:0]  grant_nx;
  logic [N-1:0]  pick;
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nx;
  logic [PW-1:0] gidx;
  logic          locked;
  logic          start;
  logic          fire_last;
  rr_pick #(.N(N), .PW(PW)) u_pick (
    .req (req_valid),
    .ptr (ptr),
    .pick(pick)
  );
  // index of the held grant, becomes the new round-robin pointer on release
  always_comb begin
    gidx = '0;
    for (int i = 0; i < N; i++) if (grant[i]) gidx = PW'(i);
  end
  // output steering from the held grant, plus next-state decisions
  always_comb begin
    locked    = state == ST_LOCKED;
    sel       = locked ? grant : '0;
    busy      = locked;
    bus_valid = locked & |(req_valid & grant);
    bus_last  = locked & |(req_last & grant);
    req_ready = locked ? grant & {N{bus_ready}} : '0;
    start     = ~locked & |req_valid;
    fire_last = bus_valid & bus_ready & bus_last;
    state_nx  = start ? ST_LOCKED : fire_last ? ST_IDLE : state;
    grant_nx  = start ? pick : fire_last ? '0 : grant;
    ptr_nx    = fire_last ? gidx : ptr;
  end
  // state, grant and pointer registers; reset gives requester 0 first priority
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      grant <= '0;
      ptr   <= PW'(N-1);
    end else begin
      state <= state_nx;
      grant <= grant_nx;
      ptr   <= ptr_nx;
    end
  end
`ifdef RR_ARB_STATS_EN
  for (genvar g = 0; g < N; g++) begin : g_cnt
    logic [CNT_W-1:0] cnt;
    // count new grants to requester g, holding at all-ones
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) cnt <= '0;
      else if (start && pick[g] && cnt != '1) cnt <= cnt + CNT_W'(1);
    end
    assign grant_count[g*CNT_W +: CNT_W] = cnt;
  end
`endif
endmodule

// File: tb/tb_rr_bus_arbiter.sv
// tb_rr_bus_arbiter: directed self-checking bench for rr_bus_arbiter
module tb_rr_bus_arbiter;
  logic       clk;
  logic       resetn;
  logic [3:0] req_valid;
  logic [3:0] req_last;
  logic [3:0] req_ready;
  logic [3:0] sel;
  logic       bus_valid;
  logic       bus_last;
  logic       bus_ready;
  logic       busy;
`ifdef RR_ARB_STATS_EN
  logic [63:0] grant_count;
`endif
  int checks = 0;
  int errors = 0;

  rr_bus_arbiter #(.N(4), .CNT_W(16)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .sel        (sel),
    .bus_valid  (bus_valid),
    .bus_last   (bus_last),
    .bus_ready  (bus_ready),
`ifdef RR_ARB_STATS_EN
    .busy       (busy),
    .grant_count(grant_count)
`else
    .busy       (busy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    resetn = 1'b0; req_valid = 4'b1111; req_last = 4'b1111; bus_ready = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    checks++; if (sel !== 4'b0000) begin errors++; $display("FAIL reset_sel got %b want 0000", sel); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b want 0000", req_ready); end
    checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL reset_bus_valid got %b want 0", bus_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    @(negedge clk); resetn = 1'b1; #1;
    checks++; if (sel !== 4'b0000) begin errors++; $display("FAIL release_same_cycle_sel got %b want 0000", sel); end
    @(negedge clk); #1;
    checks++; if (sel !== 4'b0001) begin errors++; $display("FAIL first_grant_sel got %b want 0001", sel); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL first_grant_busy got %b want 1", busy); end
    bus_ready = 1'b1;
    @(negedge clk); req_valid = 4'b0000; bus_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_alternate;
    logic [3:0] exp [5] = '{4'b0010, 4'b0000, 4'b1000, 4'b0000, 4'b0010};
    req_valid = 4'b1010; req_last = 4'b1111; bus_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      checks++; if (sel !== exp[k]) begin errors++; $display("FAIL alt_sel[%0d] got %b want %b", k, sel, exp[k]); end
      checks++; if (req_ready !== exp[k]) begin errors++; $display("FAIL alt_ready[%0d] got %b want %b", k, req_ready, exp[k]); end
    end
    @(negedge clk); req_valid = 4'b0000;
  endtask

  task automatic test_burst;
    logic br  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic lst [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [3:0] er;
    req_valid = 4'b1111; req_last = 4'b0000; bus_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus_ready = br[k]; req_last = {1'b0, lst[k], 2'b00}; #1;
      er = br[k] ? 4'b0100 : 4'b0000;
      checks++; if (sel !== 4'b0100) begin errors++; $display("FAIL burst_sel[%0d] got %b want 0100", k, sel); end
      checks++; if (req_ready !== er) begin errors++; $display("FAIL burst_ready[%0d] got %b want %b", k, req_ready, er); end
      checks++; if (bus_last !== lst[k]) begin errors++; $display("FAIL burst_last[%0d] got %b want %b", k, bus_last, lst[k]); end
    end
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL burst_end_busy got %b want 0", busy); end
    req_valid = 4'b0000; req_last = 4'b0000;
  endtask

  task automatic test_rr_all;
    logic [3:0] exp;
    @(negedge clk); resetn = 1'b0;
    @(negedge clk); resetn = 1'b1;
    req_valid = 4'b1111; req_last = 4'b1111; bus_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk); #1;
      exp = (k % 2 == 1) ? 4'(1 << (((k - 1) / 2) % 4)) : 4'b0000;
      checks++; if (sel !== exp) begin errors++; $display("FAIL rr_sel[%0d] got %b want %b", k, sel, exp); end
    end
    req_valid = 4'b0000;
  endtask

`ifdef RR_ARB_STATS_EN
  task automatic test_stats;
    logic [15:0] f;
    for (int i = 0; i < 4; i++) begin
      f = grant_count[i*16 +: 16];
      checks++; if (f !== 16'd2) begin errors++; $display("FAIL stats_count[%0d] got %0d want 2", i, f); end
    end
    @(negedge clk);
    force dut.g_cnt[1].cnt = 16'hFFFF;
    #1 release dut.g_cnt[1].cnt;
    req_valid = 4'b0010; req_last = 4'b1111; bus_ready = 1'b1;
    @(negedge clk); #1;
    checks++; if (sel !== 4'b0010) begin errors++; $display("FAIL stats_sel got %b want 0010", sel); end
    f = grant_count[16 +: 16];
    checks++; if (f !== 16'hFFFF) begin errors++; $display("FAIL stats_saturate got %h want ffff", f); end
    f = grant_count[0 +: 16];
    checks++; if (f !== 16'd2) begin errors++; $display("FAIL stats_other got %0d want 2", f); end
    @(negedge clk); req_valid = 4'b0000;
    @(negedge clk);
  endtask
`endif

  task automatic test_reset_mid;
    req_valid = 4'b0100; req_last = 4'b0000; bus_ready = 1'b1;
    @(negedge clk); #1;
    checks++; if (sel !== 4'b0100) begin errors++; $display("FAIL mid_beat1_sel got %b want 0100", sel); end
    @(negedge clk); #2;
    resetn = 1'b0; #1;
    checks++; if (sel !== 4'b0000) begin errors++; $display("FAIL mid_async_sel got %b want 0000", sel); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_async_busy got %b want 0", busy); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_async_ready got %b want 0000", req_ready); end
    @(negedge clk); resetn = 1'b1; req_valid = 4'b1111; req_last = 4'b1111;
    @(negedge clk); #1;
    checks++; if (sel !== 4'b0001) begin errors++; $display("FAIL mid_regrant_sel got %b want 0001", sel); end
    @(negedge clk); req_valid = 4'b0000;
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_alternate;
    test_burst;
    test_rr_all;
`ifdef RR_ARB_STATS_EN
    test_stats;
`endif
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
